// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings, register map and reset values for the data memory unit
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int PERIPH_BIT = 31;
    typedef enum logic [1:0] {
        REG_GPIO    = 2'd0,
        REG_CYCLE   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_off_e;
    localparam int ST_TIMER    = 0;
    localparam int ST_MISALIGN = 1;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
    // Only loads have an unsigned-halfword encoding; a store with funct3=101 is simply ignored
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a, input logic is_load);
        logic half;
        half = (f3 == F3_H) || (is_load && f3 == F3_HU);
        return (half && a[0]) || (f3 == F3_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: datapath-to-data-memory bus
interface data_memory_unit_if;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] Read_Data;
    modport master (output mem_write, mem_read, funct3, addr, write_data, input Read_Data);
    modport slave (input mem_write, mem_read, funct3, addr, write_data, output Read_Data);
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: word RAM with per-byte write enables and asynchronous read
module dmem_ram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wd,
    output logic [31:0]                    q
);
    logic [31:0] mem [DEPTH_WORDS];
    // Byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
    assign q = mem[idx];
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: RV32I data memory stage with RAM and memory-mapped GPIO/timer/status
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int GPIO_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    data_memory_unit_if.slave     bus,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq,
    output logic                  misalign_err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [31:0] cycle, compare, ram_q, ram_wd, ram_ld, per_rd;
    logic [1:0]  status, a_lo, w1c;
    logic [3:0]  ram_be;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        periph, ld_mis, st_mis, per_ok, per_wr, mis_set, hit;
    reg_off_e    off;
    logic        unused_addr;

    assign periph      = bus.addr[PERIPH_BIT];
    assign off         = reg_off_e'(bus.addr[3:2]);
    assign a_lo        = bus.addr[1:0];
    assign unused_addr = ^bus.addr[30:IW+2];
    assign ld_mis      = misaligned(bus.funct3, a_lo, 1'b1);
    // Peripheral registers only accept aligned word stores; anything else is flagged
    assign per_ok      = (bus.funct3 == F3_W) && (a_lo == 2'b00);
    assign st_mis      = periph ? !per_ok : misaligned(bus.funct3, a_lo, 1'b0);
    assign per_wr      = bus.mem_write && RST && periph && per_ok;
    assign mis_set     = (bus.mem_write && st_mis) || (bus.mem_read && ld_mis);
    assign hit         = (cycle == compare);
    assign w1c         = (per_wr && off == REG_STATUS) ? bus.write_data[1:0] : 2'b00;

    // Store lane steering: replicate the data and enable only the addressed lanes
    always_comb begin
        ram_be = (!bus.mem_write || !RST || periph || st_mis) ? 4'b0000 :
                 (bus.funct3 == F3_B) ? 4'b0001 << a_lo :
                 (bus.funct3 == F3_H) ? (a_lo[1] ? 4'b1100 : 4'b0011) :
                 (bus.funct3 == F3_W) ? 4'b1111 : 4'b0000;
        ram_wd = (bus.funct3 == F3_B) ? {4{bus.write_data[7:0]}} :
                 (bus.funct3 == F3_H) ? {2{bus.write_data[15:0]}} : bus.write_data;
    end

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk (CLK),
        .be  (ram_be),
        .idx (bus.addr[IW+1:2]),
        .wd  (ram_wd),
        .q   (ram_q)
    );

    // Load path: lane extraction and extension, peripheral mux, misaligned loads forced to zero
    always_comb begin
        byte_v = ram_q[{a_lo, 3'b000} +: 8];
        half_v = a_lo[1] ? ram_q[31:16] : ram_q[15:0];
        ram_ld = (bus.funct3 == F3_B)  ? {{24{byte_v[7]}}, byte_v} :
                 (bus.funct3 == F3_BU) ? {24'b0, byte_v} :
                 (bus.funct3 == F3_H)  ? {{16{half_v[15]}}, half_v} :
                 (bus.funct3 == F3_HU) ? {16'b0, half_v} :
                 (bus.funct3 == F3_W)  ? ram_q : 32'b0;
        per_rd = (off == REG_GPIO)    ? 32'(gpio_out) :
                 (off == REG_CYCLE)   ? cycle :
                 (off == REG_COMPARE) ? compare : {30'b0, status};
        bus.Read_Data = (bus.mem_read && ld_mis) ? 32'b0 : periph ? per_rd : ram_ld;
    end

    // GPIO output register
    always_ff @(posedge CLK) begin
        if (!RST) gpio_out <= '0;
        else if (per_wr && off == REG_GPIO) gpio_out <= bus.write_data[GPIO_WIDTH-1:0];
    end

    // Free-running cycle counter; a store replaces the increment for that cycle
    always_ff @(posedge CLK) begin
        if (!RST) cycle <= '0;
        else cycle <= (per_wr && off == REG_CYCLE) ? bus.write_data : cycle + 32'd1;
    end

    // Compare register
    always_ff @(posedge CLK) begin
        if (!RST) compare <= COMPARE_RST;
        else if (per_wr && off == REG_COMPARE) compare <= bus.write_data;
    end

    // Sticky flags: W1C clear applied first so a same-cycle set wins
    always_ff @(posedge CLK) begin
        if (!RST) status <= '0;
        else begin
            status[ST_TIMER]    <= (status[ST_TIMER] && !w1c[ST_TIMER]) || hit;
            status[ST_MISALIGN] <= (status[ST_MISALIGN] && !w1c[ST_MISALIGN]) || mis_set;
        end
    end

    assign timer_irq    = status[ST_TIMER];
    assign misalign_err = status[ST_MISALIGN];
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed self-checking bench for data_memory_unit
module tb_data_memory_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpio;
    logic       tirq, merr;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    data_memory_unit_if bus ();

    data_memory_unit #(.DEPTH_WORDS(256), .GPIO_WIDTH(8)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .bus          (bus),
        .gpio_out     (gpio),
        .timer_irq    (tirq),
        .misalign_err (merr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        bus.mem_write  = 1'b1;
        bus.addr       = a;
        bus.write_data = d;
        bus.funct3     = f3;
        tick();
        bus.mem_write  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
        bus.mem_read = 1'b1;
        bus.addr     = a;
        bus.funct3   = f3;
        #1;
        chk(tag, bus.Read_Data, exp);
        bus.mem_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.funct3     = 3'b010;
        bus.addr       = '0;
        bus.write_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_gpio", 32'(gpio), 32'h0);
        chk("rst_tirq", 32'(tirq), 32'h0);
        chk("rst_merr", 32'(merr), 32'h0);
        load("rst_status", 32'h8000_000C, 3'b010, 32'h0);
        load("rst_compare", 32'h8000_0008, 3'b010, 32'hFFFF_FFFF);
        load("rst_cycle", 32'h8000_0004, 3'b010, 32'h0);

        store(32'h10, 32'hDEAD_BEEF, 3'b010);
        load("lb", 32'h13, 3'b000, 32'hFFFF_FFDE);
        load("lbu", 32'h13, 3'b100, 32'h0000_00DE);
        load("lh", 32'h12, 3'b001, 32'hFFFF_DEAD);
        load("lhu", 32'h12, 3'b101, 32'h0000_DEAD);
        load("lw", 32'h10, 3'b010, 32'hDEAD_BEEF);
        store(32'h11, 32'h0000_0055, 3'b000);
        load("sb_lw", 32'h10, 3'b010, 32'hDEAD_55EF);
        store(32'h12, 32'h0000_1234, 3'b001);
        load("sh_lw", 32'h10, 3'b010, 32'h1234_55EF);
        load("alias_lw", 32'h410, 3'b010, 32'h1234_55EF);
        load("ld_f3_011", 32'h10, 3'b011, 32'h0);
        store(32'h10, 32'h0, 3'b011);
        load("st_f3_011", 32'h10, 3'b010, 32'h1234_55EF);
        chk("st_f3_011_noflag", 32'(merr), 32'h0);

        store(32'h20, 32'hCAFE_F00D, 3'b010);
        store(32'h22, 32'hFFFF_FFFF, 3'b010);
        load("mis_sw_lw", 32'h20, 3'b010, 32'hCAFE_F00D);
        chk("mis_sw_flag", 32'(merr), 32'h1);
        store(32'h8000_000C, 32'h2, 3'b010);
        chk("w1c_merr", 32'(merr), 32'h0);

        bus.mem_read = 1'b1;
        bus.addr     = 32'h11;
        bus.funct3   = 3'b001;
        #1;
        chk("mis_lh_data", bus.Read_Data, 32'h0);
        tick();
        bus.mem_read = 1'b0;
        chk("mis_lh_flag", 32'(merr), 32'h1);
        store(32'h8000_000C, 32'h2, 3'b010);
        chk("w1c_merr2", 32'(merr), 32'h0);

        store(32'h8000_0000, 32'h0000_01A5, 3'b010);
        chk("gpio_sw", 32'(gpio), 32'hA5);
        load("gpio_lb", 32'h8000_0000, 3'b000, 32'h0000_00A5);
        store(32'h8000_0000, 32'h11, 3'b000);
        chk("gpio_sb_ignored", 32'(gpio), 32'hA5);
        chk("gpio_sb_flag", 32'(merr), 32'h1);
        store(32'h8000_000C, 32'h2, 3'b010);

        store(32'h8000_0004, 32'hFFFF_FFFE, 3'b010);
        store(32'h8000_0008, 32'h0000_0001, 3'b010);
        load("cyc_ffff", 32'h8000_0004, 3'b010, 32'hFFFF_FFFF);
        tick();
        load("cyc_wrap", 32'h8000_0004, 3'b010, 32'h0);
        tick();
        load("cyc_one", 32'h8000_0004, 3'b010, 32'h1);
        chk("tirq_before", 32'(tirq), 32'h0);
        tick();
        chk("tirq_set", 32'(tirq), 32'h1);
        load("status_timer", 32'h8000_000C, 3'b010, 32'h1);
        store(32'h8000_000C, 32'h1, 3'b010);
        chk("tirq_w1c", 32'(tirq), 32'h0);
        load("cyc_three", 32'h8000_0004, 3'b010, 32'h3);

        store(32'h22, 32'h0, 3'b010);
        chk("pre_rst_merr", 32'(merr), 32'h1);
        rst_n          = 1'b0;
        bus.mem_write  = 1'b1;
        bus.addr       = 32'h8000_0000;
        bus.write_data = 32'h77;
        bus.funct3     = 3'b010;
        tick();
        rst_n         = 1'b1;
        bus.mem_write = 1'b0;
        chk("rst2_gpio", 32'(gpio), 32'h0);
        chk("rst2_merr", 32'(merr), 32'h0);
        chk("rst2_tirq", 32'(tirq), 32'h0);
        load("rst2_cycle", 32'h8000_0004, 3'b010, 32'h0);
        load("rst2_status", 32'h8000_000C, 3'b010, 32'h0);
        load("rst2_compare", 32'h8000_0008, 3'b010, 32'hFFFF_FFFF);
        tick();
        load("rst2_cycle1", 32'h8000_0004, 3'b010, 32'h1);
        load("ram_kept", 32'h10, 3'b010, 32'h1234_55EF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
